// File: rtl/ecc_pkg.sv
// ECC scrubber shared types and default widths.
// Imported by the scrubber top and its interval timer.
package ecc_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CW_W   = 72;
  localparam int INTV_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    RESP,
    CHECK,
    WRITE,
    NEXT
  } scrub_state_t;

endpackage

// File: rtl/ecc_scrubber_timer.sv
// Interval down-counter for the scrubber.
// Load wins over decrement; zero flag is combinational.
module scrub_timer
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_dec,
  input  logic [INTV_W-1:0] i_value,
  output logic              o_zero
);

  logic [INTV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - INTV_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks memory, checks each word
// through an external SECDED decoder, writes back single-bit fixes.
module ecc_scrubber
  import ecc_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          CW_W      = DEF_CW_W,
  parameter int unsigned LAST_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [INTV_W-1:0] scrub_interval,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic [CW_W-1:0]   dec_cw_in,
  input  logic [CW_W-1:0]   dec_cw_fixed,
  input  logic              dec_single,
  input  logic              dec_double,
  output logic              valid,
  output logic              single_error,
  output logic              double_error,
  output logic              busy,
  output logic              sweep_done,
  output logic              dbl_seen,
  output logic [ADDR_W-1:0] dbl_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  scrub_state_t      r_state;
  scrub_state_t      w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CW_W-1:0]   r_cw;
  logic [CW_W-1:0]   r_fix;
  logic              r_dbl_seen;
  logic [ADDR_W-1:0] r_dbl_addr;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic              w_wrap;

  scrub_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .i_value (scrub_interval),
    .o_zero  (w_zero)
  );

  assign w_wrap = (r_addr == LAST);

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    valid        = 1'b0;
    single_error = 1'b0;
    double_error = 1'b0;
    sweep_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_next = WAIT;
          w_load = 1'b1;
        end
      end
      WAIT: begin
        if (w_zero) w_next = READ;
        else        w_dec  = 1'b1;
      end
      READ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_next = RESP;
      end
      RESP: begin
        if (mem_rvalid) w_next = CHECK;
      end
      CHECK: begin
        valid = 1'b1;
        // a double report overrides any single flag
        if (dec_double) begin
          double_error = 1'b1;
          w_next       = NEXT;
        end else if (dec_single) begin
          single_error = 1'b1;
          w_next       = WRITE;
        end else begin
          w_next = NEXT;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) w_next = NEXT;
      end
      NEXT: begin
        sweep_done = w_wrap;
        if (enable) begin
          w_next = WAIT;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_cw       <= '0;
      r_fix      <= '0;
      r_dbl_seen <= 1'b0;
      r_dbl_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RESP && mem_rvalid) begin
        r_cw <= mem_rdata;
      end
      if (r_state == CHECK) begin
        if (dec_double) begin
          r_dbl_seen <= 1'b1;
          r_dbl_addr <= r_addr;
        end else if (dec_single) begin
          r_fix <= dec_cw_fixed;
        end
      end
      if (r_state == NEXT) begin
        r_addr <= w_wrap ? '0 : r_addr + ADDR_W'(1);
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_fix;
  assign dec_cw_in = r_cw;
  assign dbl_seen  = r_dbl_seen;
  assign dbl_addr  = r_dbl_addr;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber: memory, decoder stub,
// table-driven sweeps, randomized sweeps and corner sequences.
module tb_ecc_scrubber;

  localparam int AW   = 4;
  localparam int CW   = 72;
  localparam int LAST = 3;
  localparam int NW   = LAST + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   intv;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [CW-1:0] mem_rdata = '0;
  logic [CW-1:0] dec_cw_in, dec_cw_fixed;
  logic          dec_single, dec_double;
  logic          valid, single_error, double_error;
  logic          busy, sweep_done, dbl_seen;
  logic [AW-1:0] dbl_addr;

  always #5 clk = ~clk;

  ecc_scrubber #(.ADDR_W(AW), .CW_W(CW), .LAST_ADDR(LAST)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .scrub_interval(intv),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .dec_cw_in(dec_cw_in), .dec_cw_fixed(dec_cw_fixed),
    .dec_single(dec_single), .dec_double(dec_double),
    .valid(valid), .single_error(single_error),
    .double_error(double_error),
    .busy(busy), .sweep_done(sweep_done),
    .dbl_seen(dbl_seen), .dbl_addr(dbl_addr)
  );

  logic [CW-1:0] golden [16];
  logic [CW-1:0] mem    [16];
  logic [CW-1:0] pre    [16];

  // decoder stub: distance from the known-good word at this address
  logic [CW-1:0] dg;
  int            dn;
  assign dg           = golden[mem_addr];
  assign dn           = $countones(dec_cw_in ^ dg);
  assign dec_single   = (dn == 1);
  assign dec_double   = (dn >= 2);
  assign dec_cw_fixed = (dn == 1) ? dg : dec_cw_in;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  bit            gnt_en = 1'b1;
  int            stall_pct = 0;
  int            lat = 1;
  int            pcnt = 0;
  logic [CW-1:0] pdata;
  int            rd_gnt_cnt = 0;
  int            sd_cnt = 0;
  int            v_cyc[$];
  int            v_addr[$];
  bit            v_s[$];
  bit            v_d[$];
  int            w_addr[$];
  logic [CW-1:0] w_data[$];

  // memory model and event observer
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pcnt > 0) begin
      pcnt = pcnt - 1;
      if (pcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pdata;
      end
    end
    mem_gnt = mem_req && gnt_en && ($urandom_range(99) >= stall_pct);
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        w_addr.push_back(int'(mem_addr));
        w_data.push_back(mem_wdata);
      end else begin
        pcnt  = lat;
        pdata = mem[mem_addr];
        rd_gnt_cnt++;
      end
    end
    if (valid) begin
      v_cyc.push_back(cyc);
      v_addr.push_back(int'(mem_addr));
      v_s.push_back(single_error);
      v_d.push_back(double_error);
    end
    if (sweep_done) sd_cnt++;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] flips(input int n);
    logic [CW-1:0] m = '0;
    while ($countones(m) < n) m[$urandom_range(CW-1)] = 1'b1;
    return m;
  endfunction

  bit            m_dbl = 1'b0;
  int            m_dbl_addr = 0;

  // one full sweep from addr 0, stopping in IDLE after the last word
  task automatic sweep(input string tag);
    int t = 0;
    int nw = 0;
    int n;
    bit to = 1'b0;
    pre = mem;
    v_cyc.delete(); v_addr.delete();
    v_s.delete(); v_d.delete();
    w_addr.delete(); w_data.delete();
    sd_cnt = 0;
    enable = 1'b1;
    forever begin
      @(negedge clk);
      t++;
      if (valid && mem_addr == AW'(LAST)) enable = 1'b0;
      if (t > 2 && !busy && !enable) break;
      if (t > 4000) begin
        to = 1'b1;
        enable = 1'b0;
        break;
      end
    end
    chk({tag, " timeout"}, 128'(to), 0);
    chk({tag, " nvalid"}, v_addr.size(), NW);
    for (int a = 0; a < NW; a++) begin
      n = $countones(pre[a] ^ golden[a]);
      if (a < v_addr.size()) begin
        chk($sformatf("%s addr%0d", tag, a), v_addr[a], a);
        chk($sformatf("%s sgl%0d", tag, a), 128'(v_s[a]),
            128'(n == 1));
        chk($sformatf("%s dbl%0d", tag, a), 128'(v_d[a]),
            128'(n >= 2));
      end
      if (n == 1) begin
        if (nw < w_addr.size()) begin
          chk($sformatf("%s waddr%0d", tag, a), w_addr[nw], a);
          chk($sformatf("%s wdata%0d", tag, a), w_data[nw],
              golden[a]);
        end
        nw++;
      end
      if (n >= 2) begin
        m_dbl = 1'b1;
        m_dbl_addr = a;
      end
      chk($sformatf("%s mem%0d", tag, a), mem[a],
          (n == 1) ? golden[a] : pre[a]);
    end
    chk({tag, " nwrites"}, w_addr.size(), nw);
    chk({tag, " sweep_done"}, sd_cnt, 1);
    chk({tag, " addr_wrap"}, mem_addr, 0);
    chk({tag, " busy"}, 128'(busy), 0);
    chk({tag, " dbl_seen"}, 128'(dbl_seen), 128'(m_dbl));
    chk({tag, " dbl_addr"}, dbl_addr, m_dbl_addr);
  endtask

  typedef struct {
    int addr;
    int nflip;
    bit restore;
    bit exp_s;
    bit exp_d;
    bit exp_wr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int t;
    int g0;
    vt[0] = '{0, 0, 1, 0, 0, 0};
    vt[1] = '{2, 1, 1, 1, 0, 1};
    vt[2] = '{2, 0, 0, 0, 0, 0};
    vt[3] = '{1, 2, 1, 0, 1, 0};
    vt[4] = '{0, 0, 1, 0, 0, 0};
    vt[5] = '{3, 3, 1, 0, 1, 0};
    vt[6] = '{0, 1, 1, 1, 0, 1};
    for (int a = 0; a < 16; a++) begin
      golden[a] = {$urandom, $urandom, $urandom};
      mem[a]    = golden[a];
    end
    reset = 1'b1;
    enable = 1'b0;
    intv = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 128'(busy), 0);
    chk("rst mem_req", 128'(mem_req), 0);
    chk("rst valid", 128'(valid), 0);
    chk("rst sweep_done", 128'(sweep_done), 0);
    chk("rst dbl_seen", 128'(dbl_seen), 0);
    chk("rst dbl_addr", dbl_addr, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst cw", dec_cw_in, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vt[i].restore) mem = golden;
      mem[vt[i].addr] = mem[vt[i].addr] ^ flips(vt[i].nflip);
      sweep($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tsgl", i), 128'(v_s[vt[i].addr]),
          128'(vt[i].exp_s));
      chk($sformatf("vec%0d tdbl", i), 128'(v_d[vt[i].addr]),
          128'(vt[i].exp_d));
      chk($sformatf("vec%0d twr", i), 128'(w_addr.size() > 0),
          128'(vt[i].exp_wr));
    end

    // word-to-word spacing: READ+RESP+CHECK+NEXT plus interval+1 WAITs
    mem = golden;
    sweep("per0");
    chk("period int0", v_cyc[1] - v_cyc[0], 5);
    intv = 16'd4;
    sweep("per4");
    chk("period int4", v_cyc[1] - v_cyc[0], 9);

    for (int r = 0; r < 6; r++) begin
      mem = golden;
      for (int a = 0; a < NW; a++) begin
        g0 = $urandom_range(3);
        mem[a] = mem[a] ^ flips((g0 == 3) ? 2 : g0 / 2 + (g0 == 2));
      end
      intv = 16'($urandom_range(3));
      lat = $urandom_range(1, 3);
      stall_pct = 30;
      sweep($sformatf("rnd%0d", r));
    end
    stall_pct = 0;

    // enable dropped while a read is outstanding
    mem = golden;
    intv = '0;
    lat = 4;
    v_addr.delete();
    g0 = rd_gnt_cnt;
    enable = 1'b1;
    t = 0;
    while (rd_gnt_cnt == g0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    chk("drop grant seen", 128'(rd_gnt_cnt - g0), 1);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("drop busy", 128'(busy), 0);
    chk("drop nvalid", v_addr.size(), 1);
    chk("drop reads", 128'(rd_gnt_cnt - g0), 1);
    chk("drop addr", mem_addr, 1);
    lat = 1;

    // ungranted read held, then reset mid-request
    gnt_en = 1'b0;
    enable = 1'b1;
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall req%0d", k), 128'(mem_req), 1);
      chk($sformatf("stall we%0d", k), 128'(mem_we), 0);
      chk($sformatf("stall addr%0d", k), mem_addr, 1);
      if (k < 4) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst2 mem_req", 128'(mem_req), 0);
    chk("rst2 busy", 128'(busy), 0);
    chk("rst2 addr", mem_addr, 0);
    chk("rst2 dbl_seen", 128'(dbl_seen), 0);
    reset = 1'b0;
    enable = 1'b0;
    gnt_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2 idle", 128'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
